rx_frame_check: RTL and testbench

Parametrised UART receive frame checker between the RX data sampler and the RX output register. It consumes one majority-sampled bit per `sample_valid` strobe and tracks the frame position itself: start, DATA_WIDTH data bits (LSB first), optional parity, and STOP_BITS stop bits. It reports start glitches, parity errors and stop errors, and delivers the deserialised word with a one-cycle valid pulse. It supersedes the single-flag start checker by performing start, parity and stop checking and deserialisation in one sequenced block.

---
 rtl/rx_frame_check.sv | 226 ++++++++++++++++++++++
 tb/tb_rx_frame_check.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_check.sv
// rx_frame_check
// ---------------------------------------------------------------------------
// UART receive frame checker. Consumes one majority-sampled bit per
// sample_valid strobe and walks the frame itself: start bit, DATA_WIDTH data
// bits (LSB first), optional parity bit, STOP_BITS stop bits. Flags start
// glitches, parity errors and stop errors, and delivers the deserialised word
// with a one-cycle data_valid pulse. All outputs are registered.
//
// Parameters
//   DATA_WIDTH    data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   enable        block enable; low forces IDLE and discards a partial frame
//   sample_valid  one-cycle strobe: sampled_bit holds a new bit
//   sampled_bit   sampled line value
//   par_en        parity bit present (latched at the start bit)
//   par_type      0 = even, 1 = odd (latched at the start bit)
//   p_data        last error-free word
//   data_valid    one-cycle pulse: p_data updated
//   start_glitch  one-cycle pulse: start bit sampled as 1
//   par_err       one-cycle pulse: parity mismatch
//   stp_err       one-cycle pulse: a stop bit sampled as 0
//   busy          high in any state other than IDLE
//   err_cnt       (only with RX_FRAME_ERR_CNT_EN) saturating 8-bit count of
//                 cycles in which any error pulse fires
//
// Optional feature macro: RX_FRAME_ERR_CNT_EN
// ---------------------------------------------------------------------------
module rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  start_glitch,
  output logic                  par_err,
  output logic                  stp_err,
`ifdef RX_FRAME_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  // The same counter indexes data bits and stop bits; DATA_WIDTH >= 5 makes
  // it wide enough for either.
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  xor_q, xor_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_fail_q, par_fail_d;
  logic                  stp_fail_q, stp_fail_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  start_glitch_q, start_glitch_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  busy_q, busy_d;

  logic                  exp_par;
  logic                  stp_fail_now;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    xor_d          = xor_q;
    par_en_d       = par_en_q;
    par_type_d     = par_type_q;
    par_fail_d     = par_fail_q;
    stp_fail_d     = stp_fail_q;
    p_data_d       = p_data_q;
    data_valid_d   = 1'b0;
    start_glitch_d = 1'b0;
    par_err_d      = 1'b0;
    stp_err_d      = 1'b0;

    // Even parity expects the data XOR; odd expects its complement.
    exp_par      = par_type_q ? ~xor_q : xor_q;
    // Include the bit being consumed so the final stop bit is judged now.
    stp_fail_now = stp_fail_q | ~sampled_bit;

    if (!enable) begin
      // Abandon any partial frame silently.
      state_d    = IDLE;
      bit_cnt_d  = '0;
      par_fail_d = 1'b0;
      stp_fail_d = 1'b0;
    end else if (sample_valid) begin
      case (state_q)
        IDLE: begin
          if (!sampled_bit) begin
            par_en_d   = par_en;
            par_type_d = par_type;
            bit_cnt_d  = '0;
            xor_d      = 1'b0;
            par_fail_d = 1'b0;
            stp_fail_d = 1'b0;
            state_d    = DATA;
          end else begin
            start_glitch_d = 1'b1;
          end
        end
        DATA: begin
          // LSB arrives first: shift right, insert at the MSB.
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          xor_d   = xor_q ^ sampled_bit;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (sampled_bit != exp_par) par_fail_d = 1'b1;
          bit_cnt_d = '0;
          state_d   = STOP;
        end
        default: begin  // STOP
          if (bit_cnt_q == LAST_STOP) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            par_fail_d = 1'b0;
            stp_fail_d = 1'b0;
            if (!par_fail_q && !stp_fail_now) begin
              p_data_d     = shift_q;
              data_valid_d = 1'b1;
            end else begin
              par_err_d = par_fail_q;
              stp_err_d = stp_fail_now;
            end
          end else begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
            stp_fail_d = stp_fail_now;
          end
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      xor_q          <= 1'b0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      par_fail_q     <= 1'b0;
      stp_fail_q     <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      start_glitch_q <= 1'b0;
      par_err_q      <= 1'b0;
      stp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      xor_q          <= xor_d;
      par_en_q       <= par_en_d;
      par_type_q     <= par_type_d;
      par_fail_q     <= par_fail_d;
      stp_fail_q     <= stp_fail_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      start_glitch_q <= start_glitch_d;
      par_err_q      <= par_err_d;
      stp_err_q      <= stp_err_d;
      busy_q         <= busy_d;
    end
  end

`ifdef RX_FRAME_ERR_CNT_EN
  // Counts on the same edge as the error pulses so the count and the pulse
  // become visible together; several simultaneous pulses count once.
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_any;

  always_comb begin
    err_any   = start_glitch_d | par_err_d | stp_err_d;
    err_cnt_d = err_cnt_q;
    if (err_any && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt_q <= 8'd0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign p_data       = p_data_q;
  assign data_valid   = data_valid_q;
  assign start_glitch = start_glitch_q;
  assign par_err      = par_err_q;
  assign stp_err      = stp_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rx_frame_check.sv
// Testbench for rx_frame_check. Two instances share clock, reset, enable,
// line value and parity configuration: dut1 has one stop bit, dut2 has two.
// Each has its own sample_valid strobe. Stimulus pushes hand-computed
// expected output events into a per-instance queue; monitors pop and compare
// whenever an instance raises any output pulse.
module tb_rx_frame_check;

  typedef struct packed {
    logic       dv;
    logic       gl;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       sv1, sv2;
  logic       sampled_bit;
  logic       par_en;
  logic       par_type;

  logic [7:0] p_data1, p_data2;
  logic       dv1, dv2, gl1, gl2, pe1, pe2, se1, se2, busy1, busy2;
`ifdef RX_FRAME_ERR_CNT_EN
  logic [7:0] err_cnt1, err_cnt2;
`endif

  int tests;
  int fails;

  ev_t q1[$];
  ev_t q2[$];

  rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sv1),
    .sampled_bit  (sampled_bit),
    .par_en       (par_en),
    .par_type     (par_type),
    .p_data       (p_data1),
    .data_valid   (dv1),
    .start_glitch (gl1),
    .par_err      (pe1),
    .stp_err      (se1),
`ifdef RX_FRAME_ERR_CNT_EN
    .err_cnt      (err_cnt1),
`endif
    .busy         (busy1)
  );

  rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sv2),
    .sampled_bit  (sampled_bit),
    .par_en       (par_en),
    .par_type     (par_type),
    .p_data       (p_data2),
    .data_valid   (dv2),
    .start_glitch (gl2),
    .par_err      (pe2),
    .stp_err      (se2),
`ifdef RX_FRAME_ERR_CNT_EN
    .err_cnt      (err_cnt2),
`endif
    .busy         (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic push(input int sel, input logic dv, input logic gl, input logic pe,
                      input logic se, input logic [7:0] data);
    ev_t e;
    e = '{dv: dv, gl: gl, pe: pe, se: se, data: data};
    if (sel == 1) q1.push_back(e);
    else          q2.push_back(e);
  endtask

  // Monitors: compare every cycle in which an instance shows any pulse.
  always @(negedge clk) begin
    ev_t a, e;
    if (rst && (dv1 || gl1 || pe1 || se1)) begin
      a = '{dv: dv1, gl: gl1, pe: pe1, se: se1, data: p_data1};
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL dut1_unexpected: got %b/%b/%b/%b data 0x%02h required no pulse",
                 a.dv, a.gl, a.pe, a.se, a.data);
      end else begin
        e = q1.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL dut1_event: got dv/gl/pe/se %b%b%b%b data 0x%02h required %b%b%b%b data 0x%02h",
                   a.dv, a.gl, a.pe, a.se, a.data, e.dv, e.gl, e.pe, e.se, e.data);
        end else begin
          $display("ok   dut1_event: dv/gl/pe/se %b%b%b%b data 0x%02h", a.dv, a.gl, a.pe, a.se, a.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    ev_t a, e;
    if (rst && (dv2 || gl2 || pe2 || se2)) begin
      a = '{dv: dv2, gl: gl2, pe: pe2, se: se2, data: p_data2};
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL dut2_unexpected: got %b/%b/%b/%b data 0x%02h required no pulse",
                 a.dv, a.gl, a.pe, a.se, a.data);
      end else begin
        e = q2.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL dut2_event: got dv/gl/pe/se %b%b%b%b data 0x%02h required %b%b%b%b data 0x%02h",
                   a.dv, a.gl, a.pe, a.se, a.data, e.dv, e.gl, e.pe, e.se, e.data);
        end else begin
          $display("ok   dut2_event: dv/gl/pe/se %b%b%b%b data 0x%02h", a.dv, a.gl, a.pe, a.se, a.data);
        end
      end
    end
  end

  // One strobe, consumed at the next rising edge, then `gap` idle cycles.
  task automatic send_bit(input int sel, input logic b, input int gap);
    if (sel == 1) sv1 = 1'b1;
    else          sv2 = 1'b1;
    sampled_bit = b;
    @(posedge clk); #1;
    sv1 = 1'b0;
    sv2 = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int sel, input logic [7:0] d, input bit with_par,
                       input logic pbit, input logic s0, input logic s1,
                       input int nstop, input int gap, input bit flip_cfg);
    send_bit(sel, 1'b0, gap);
    if (flip_cfg) begin
      par_en   = ~par_en;
      par_type = ~par_type;
    end
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], gap);
    if (with_par) send_bit(sel, pbit, gap);
    send_bit(sel, s0, gap);
    if (nstop == 2) send_bit(sel, s1, gap);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    enable = 1'b1;
    sv1 = 1'b0;
    sv2 = 1'b0;
    sampled_bit = 1'b1;
    par_en = 1'b0;
    par_type = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_p_data1", {24'd0, p_data1}, 32'h00);
    check("reset_flags1", {28'd0, dv1, gl1, pe1, se1}, 32'h0);
    check("reset_busy1", {31'd0, busy1}, 32'h0);
    check("reset_p_data2", {24'd0, p_data2}, 32'h00);
    check("reset_busy2", {31'd0, busy2}, 32'h0);
`ifdef RX_FRAME_ERR_CNT_EN
    check("reset_err_cnt1", {24'd0, err_cnt1}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Even parity, 0xA5, parity bit 0 -> good word.
    par_en = 1'b1; par_type = 1'b0;
    push(1, 1, 0, 0, 0, 8'hA5);
    send_bit(1, 1'b0, 1);
    check("busy_after_start", {31'd0, busy1}, 32'h1);
    for (int i = 0; i < 8; i++) send_bit(1, (i == 0 || i == 2 || i == 5 || i == 7), 1);
    send_bit(1, 1'b0, 0);      // parity
    send_bit(1, 1'b1, 0);      // stop: consumed at this edge
    check("busy_fall_with_dv", {31'd0, busy1}, 32'h0);
    @(posedge clk); #1;

    // Even parity, 0x3C (four ones) -> good word, sets a distinct p_data.
    push(1, 1, 0, 0, 0, 8'h3C);
    frame(1, 8'h3C, 1, 1'b0, 1'b1, 1'b1, 1, 1, 0);

    // Odd parity, 0xA5 with parity bit 0 -> parity error, p_data holds 0x3C.
    par_type = 1'b1;
    push(1, 0, 0, 1, 0, 8'h3C);
    frame(1, 8'hA5, 1, 1'b0, 1'b1, 1'b1, 1, 1, 0);

    // Start glitch in IDLE, busy stays low, then a normal even-parity frame.
    par_type = 1'b0;
    push(1, 0, 1, 0, 0, 8'h3C);
    send_bit(1, 1'b1, 1);
    check("busy_after_glitch", {31'd0, busy1}, 32'h0);
    push(1, 1, 0, 0, 0, 8'h81);
    frame(1, 8'h81, 1, 1'b0, 1'b1, 1'b1, 1, 1, 0);

    // No parity, stop bit 0 -> stop error.
    par_en = 1'b0;
    push(1, 0, 0, 0, 1, 8'h81);
    frame(1, 8'h12, 0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
`ifdef RX_FRAME_ERR_CNT_EN
    check("err_cnt1_before_both", {24'd0, err_cnt1}, 32'd3);
`endif

    // Wrong even parity and stop 0 -> both errors in one cycle.
    par_en = 1'b1;
    push(1, 0, 0, 1, 1, 8'h81);
    frame(1, 8'h81, 1, 1'b1, 1'b0, 1'b1, 1, 1, 0);
`ifdef RX_FRAME_ERR_CNT_EN
    check("err_cnt1_both_adds_one", {24'd0, err_cnt1}, 32'd4);
`endif

    // Abort after 4 data bits by dropping enable; strobes ignored while off.
    par_en = 1'b0;
    send_bit(1, 1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1, 1'b1, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("busy_after_disable", {31'd0, busy1}, 32'h0);
    send_bit(1, 1'b1, 1);      // would be a glitch if enabled
    send_bit(1, 1'b0, 1);      // would start a frame if enabled
    check("busy_ignored_strobe", {31'd0, busy1}, 32'h0);
    enable = 1'b1;
    push(1, 1, 0, 0, 0, 8'h0F);
    frame(1, 8'h0F, 0, 1'b0, 1'b1, 1'b1, 1, 1, 0);

    // Parity configuration flipped mid-frame: latched even parity still used.
    par_en = 1'b1; par_type = 1'b0;
    push(1, 1, 0, 0, 0, 8'hA5);
    frame(1, 8'hA5, 1, 1'b0, 1'b1, 1'b1, 1, 1, 1);
    par_en = 1'b0; par_type = 1'b0;

    // Two stop bits, back-to-back strobes: 1 then 0 -> stop error,
    // then 0x55 starting the very next cycle -> good, then 0 then 1 -> error.
    push(2, 0, 0, 0, 1, 8'h00);
    frame(2, 8'h3C, 0, 1'b0, 1'b1, 1'b0, 2, 0, 0);
    push(2, 1, 0, 0, 0, 8'h55);
    frame(2, 8'h55, 0, 1'b0, 1'b1, 1'b1, 2, 0, 0);
    check("busy2_after_b2b", {31'd0, busy2}, 32'h0);
    push(2, 0, 0, 0, 1, 8'h55);
    frame(2, 8'h55, 0, 1'b0, 1'b0, 1'b1, 2, 1, 0);

`ifdef RX_FRAME_ERR_CNT_EN
    check("err_cnt2_before_glitches", {24'd0, err_cnt2}, 32'd2);
    for (int i = 0; i < 300; i++) begin
      push(2, 0, 1, 0, 0, 8'h55);
      send_bit(2, 1'b1, 1);
    end
    check("err_cnt2_saturated", {24'd0, err_cnt2}, 32'd255);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue1_drained", q1.size(), 32'd0);
    check("queue2_drained", q2.size(), 32'd0);

    // Reset mid-frame returns outputs to reset values immediately.
    send_bit(1, 1'b0, 1);
    send_bit(1, 1'b1, 1);
    check("busy_mid_frame", {31'd0, busy1}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_busy1", {31'd0, busy1}, 32'h0);
    check("async_reset_p_data1", {24'd0, p_data1}, 32'h00);
    check("async_reset_p_data2", {24'd0, p_data2}, 32'h00);
`ifdef RX_FRAME_ERR_CNT_EN
    check("async_reset_err_cnt2", {24'd0, err_cnt2}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
